pong_score_ctrl: RTL and testbench

//  Game-flow and score keeper for the two-player pong screen. Counts points per player in BCD,

---
 rtl/pong_score_ctrl_pkg.sv | 34 +++
 rtl/bcd2_counter.sv | 41 ++++
 rtl/pong_score_ctrl.sv | 148 ++++++++++++++
 tb/tb_pong_score_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_score_ctrl_pkg.sv
// Shared types and BCD helpers for the pong score/game-flow controller.
package pong_score_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

    localparam int BCD_W = 4;

    // Two-digit BCD increment that holds at 99 instead of wrapping.
    function automatic logic [2*BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] tens,
                                                   input logic [BCD_W-1:0] ones);
        if (tens == 4'd9 && ones == 4'd9)
            return {tens, ones};
        else if (ones == 4'd9)
            return {tens + 4'd1, 4'd0};
        else
            return {tens, ones + 4'd1};
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [2*BCD_W-1:0] bcd);
        return 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD point counter, saturating at 99; clear has priority over increment.
module bcd2_counter
    import pong_score_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc) begin
            {tens_d, ones_d} = bcd_inc(tens_q, ones_q);
        end
    end

    // NOTE: non-blocking here so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/pong_score_ctrl.sv
// Pong game-flow FSM (IDLE/SERVE/PLAY/OVER) with per-player BCD scores and overlay outputs.
module pong_score_ctrl
    import pong_score_ctrl_pkg::*;
#(
    parameter logic [6:0] WIN_SCORE    = 7'd11,
    parameter logic [7:0] SERVE_FRAMES = 8'd60,
    parameter logic [7:0] OVER_FRAMES  = 8'd120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [1:0] game_state,
    output logic       ball_run,
    output logic       ball_reset,
    output logic [1:0] winner
);

    state_e     state_q, state_d;
    winner_e    winner_q, winner_d;
    logic [7:0] frame_q, frame_d;
    logic       btn_d_q;
    logic       ball_run_q, ball_run_d;
    logic       ball_reset_q, ball_reset_d;

    logic       start_rise;
    logic       score_clr, p1_inc, p2_inc;
    logic       p1_win, p2_win;
    logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;

    assign start_rise = btn_start & ~btn_d_q;

    // Win is judged on the post-increment score so OVER is entered on the scoring cycle.
    assign p1_win = (bcd_to_bin(bcd_inc(p1_tens, p1_ones)) == WIN_SCORE);
    assign p2_win = (bcd_to_bin(bcd_inc(p2_tens, p2_ones)) == WIN_SCORE);

    bcd2_counter u_p1_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (p1_inc),
        .tens  (p1_tens),
        .ones  (p1_ones)
    );

    bcd2_counter u_p2_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (p2_inc),
        .tens  (p2_tens),
        .ones  (p2_ones)
    );

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        frame_d      = frame_q;
        ball_reset_d = 1'b0;
        score_clr    = 1'b0;
        p1_inc       = 1'b0;
        p2_inc       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    score_clr    = 1'b1;
                    ball_reset_d = 1'b1;
                    state_d      = ST_SERVE;
                    frame_d      = '0;
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    if (frame_q == SERVE_FRAMES - 8'd1) begin
                        state_d = ST_PLAY;
                        frame_d = '0;
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                // A simultaneous point goes to player 1; player 2's pulse is dropped.
                if (p1_point || p2_point) begin
                    p1_inc  = p1_point;
                    p2_inc  = p2_point & ~p1_point;
                    frame_d = '0;
                    if ((p1_point && p1_win) || (!p1_point && p2_win)) begin
                        state_d  = ST_OVER;
                        winner_d = p1_point ? WIN_P1 : WIN_P2;
                    end else begin
                        state_d      = ST_SERVE;
                        ball_reset_d = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (tick && frame_q != OVER_FRAMES)
                    frame_d = frame_q + 8'd1;
                if (start_rise && frame_q == OVER_FRAMES) begin
                    score_clr    = 1'b1;
                    winner_d     = WIN_NONE;
                    ball_reset_d = 1'b1;
                    state_d      = ST_SERVE;
                    frame_d      = '0;
                end
            end
        endcase

        ball_run_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            winner_q     <= WIN_NONE;
            frame_q      <= '0;
            btn_d_q      <= 1'b0;
            ball_run_q   <= 1'b0;
            ball_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            frame_q      <= frame_d;
            btn_d_q      <= btn_start;
            ball_run_q   <= ball_run_d;
            ball_reset_q <= ball_reset_d;
        end
    end

    assign dig1       = p1_tens;
    assign dig0       = p1_ones;
    assign dig2       = p2_tens;
    assign dig3       = p2_ones;
    assign game_state = state_q;
    assign ball_run   = ball_run_q;
    assign ball_reset = ball_reset_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Scoreboard bench for pong_score_ctrl: expected snapshots queued per clock, compared per task.
module tb_pong_score_ctrl;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SERVE = 2'b01;
    localparam logic [1:0] S_PLAY  = 2'b10;
    localparam logic [1:0] S_OVER  = 2'b11;

    logic       clk = 1'b0;
    logic       reset, tick, btn_start, p1_point, p2_point;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic [1:0] game_state, winner;
    logic       ball_run, ball_reset;

    typedef struct {
        string       name;
        logic [21:0] v;
    } exp_t;

    exp_t        exp_q[$];
    logic [21:0] obs_q[$];
    exp_t        e;
    logic [21:0] o;
    int          total = 0;
    int          bad   = 0;

    // Reference model of the game, kept in plain integers.
    logic [1:0] m_state;
    logic [1:0] m_win;
    logic       m_br;
    int         p1s, p2s;

    pong_score_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .btn_start  (btn_start),
        .p1_point   (p1_point),
        .p2_point   (p2_point),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .game_state (game_state),
        .ball_run   (ball_run),
        .ball_reset (ball_reset),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int s);
        logic [3:0] t, u;
        t = 4'(s / 10);
        u = 4'(s % 10);
        return {t, u};
    endfunction

    // Packed snapshot: {state, p1 tens/ones, p2 tens/ones, ball_run, ball_reset, winner}
    function automatic logic [21:0] mk_exp();
        return {m_state, to_bcd(p1s), to_bcd(p2s), (m_state == S_PLAY), m_br, m_win};
    endfunction

    task automatic push_exp(input string n);
        exp_q.push_back('{name: n, v: mk_exp()});
    endtask

    task automatic cyc(input logic t, input logic a, input logic b);
        tick     = t;
        p1_point = a;
        p2_point = b;
        @(posedge clk);
        #1;
        obs_q.push_back({game_state, dig1, dig0, dig2, dig3, ball_run, ball_reset, winner});
        tick     = 1'b0;
        p1_point = 1'b0;
        p2_point = 1'b0;
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_win   = 2'b00;
        m_br    = 1'b0;
        p1s     = 0;
        p2s     = 0;
    endtask

    task automatic serve_to_play();
        for (int i = 0; i < 60; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            m_br = 1'b0;
            if (i == 59) m_state = S_PLAY;
            push_exp($sformatf("serve_tick%0d", i));
        end
    endtask

    task automatic score(input logic a, input logic b, input logic t, input string n);
        cyc(t, a, b);
        m_br = 1'b0;
        if (a) begin
            p1s = (p1s < 99) ? p1s + 1 : 99;
            if (p1s == 11) begin m_state = S_OVER; m_win = 2'b01; end
            else begin m_state = S_SERVE; m_br = 1'b1; end
        end else if (b) begin
            p2s = (p2s < 99) ? p2s + 1 : 99;
            if (p2s == 11) begin m_state = S_OVER; m_win = 2'b10; end
            else begin m_state = S_SERVE; m_br = 1'b1; end
        end
        push_exp(n);
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_start = 1'b0;
        model_reset();
        cyc(1'b0, 1'b0, 1'b0); push_exp("reset_0");
        cyc(1'b1, 1'b1, 1'b0); push_exp("reset_1");
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0); push_exp("idle");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL %s: no sample", e.name); end
            else begin
                o = obs_q.pop_front();
                if (o !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
            end
        end
        if (obs_q.size() != 0) begin bad++; $display("FAIL reset_align: %0d extra samples, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_start();
        btn_start = 1'b1;
        cyc(1'b0, 1'b0, 1'b0); m_state = S_SERVE; m_br = 1'b1; push_exp("start_rise");
        cyc(1'b0, 1'b0, 1'b0); m_br = 1'b0; push_exp("start_held");
        btn_start = 1'b0;
        cyc(1'b0, 1'b0, 1'b0); push_exp("start_low");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL %s: no sample", e.name); end
            else begin
                o = obs_q.pop_front();
                if (o !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
            end
        end
        if (obs_q.size() != 0) begin bad++; $display("FAIL start_align: %0d extra samples, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    // Gap cycle between ticks carries an ignored start rise and ignored point pulses.
    task automatic test_serve();
        for (int i = 0; i < 60; i++) begin
            btn_start = (i == 10);
            cyc(1'b0, i == 20, i == 30); push_exp($sformatf("serve_gap%0d", i));
            btn_start = 1'b0;
            cyc(1'b1, 1'b0, 1'b0);
            if (i == 59) m_state = S_PLAY;
            push_exp($sformatf("serve_t%0d", i));
        end
        cyc(1'b0, 1'b0, 1'b0); push_exp("play_hold");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL %s: no sample", e.name); end
            else begin
                o = obs_q.pop_front();
                if (o !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
            end
        end
        if (obs_q.size() != 0) begin bad++; $display("FAIL serve_align: %0d extra samples, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin score(1'b1, 1'b0, k[0], "p1_pt"); serve_to_play(); end
        for (int k = 0; k < 4; k++) begin score(1'b0, 1'b1, 1'b1, "p2_pt"); serve_to_play(); end
        score(1'b1, 1'b1, 1'b1, "both_points");
        serve_to_play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL %s: no sample", e.name); end
            else begin
                o = obs_q.pop_front();
                if (o !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
            end
        end
        if (obs_q.size() != 0) begin bad++; $display("FAIL b2b_align: %0d extra samples, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_carry();
        while (p1s < 9) begin score(1'b1, 1'b0, 1'b0, "p1_to9"); serve_to_play(); end
        score(1'b1, 1'b0, 1'b0, "carry_9_to_10");
        serve_to_play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL %s: no sample", e.name); end
            else begin
                o = obs_q.pop_front();
                if (o !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
            end
        end
        if (obs_q.size() != 0) begin bad++; $display("FAIL carry_align: %0d extra samples, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_win();
        while (p2s < 10) begin score(1'b0, 1'b1, 1'b0, "p2_to10"); serve_to_play(); end
        score(1'b0, 1'b1, 1'b0, "p2_wins");
        for (int i = 0; i < 50; i++) begin cyc(1'b1, 1'b0, 1'b0); push_exp("over_tick_a"); end
        btn_start = 1'b1;
        cyc(1'b0, 1'b0, 1'b0); push_exp("start_at_50");
        btn_start = 1'b0;
        for (int i = 0; i < 69; i++) begin cyc(1'b1, 1'b0, 1'b0); push_exp("over_tick_b"); end
        btn_start = 1'b1;
        cyc(1'b0, 1'b0, 1'b0); push_exp("start_at_119");
        btn_start = 1'b0;
        for (int i = 0; i < 4; i++) begin cyc(1'b1, 1'b0, 1'b0); push_exp("over_sat"); end
        btn_start = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        m_state = S_SERVE; m_win = 2'b00; m_br = 1'b1; p1s = 0; p2s = 0;
        push_exp("restart");
        btn_start = 1'b0;
        serve_to_play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL %s: no sample", e.name); end
            else begin
                o = obs_q.pop_front();
                if (o !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
            end
        end
        if (obs_q.size() != 0) begin bad++; $display("FAIL win_align: %0d extra samples, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) begin score(1'b1, 1'b0, 1'b0, "p1_to5"); serve_to_play(); end
        for (int k = 0; k < 7; k++) begin score(1'b0, 1'b1, 1'b0, "p2_to7"); serve_to_play(); end
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        model_reset();
        push_exp("reset_in_play");
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0); push_exp("idle_after_reset");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL %s: no sample", e.name); end
            else begin
                o = obs_q.pop_front();
                if (o !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
            end
        end
        if (obs_q.size() != 0) begin bad++; $display("FAIL rmid_align: %0d extra samples, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; btn_start = 1'b0; p1_point = 1'b0; p2_point = 1'b0;
        test_reset();
        test_start();
        test_serve();
        test_back_to_back();
        test_carry();
        test_win();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

endmodule
